// File: rtl/term_pkg.sv
// Shared constants, control codes and state encoding for the text terminal
// controller. Geometry is fixed at 80x30 cells backing a 2400-entry char RAM.
package term_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TAB_W  = 8;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned CELLS  = COLS * ROWS;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_PR_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CLR_LINE = 2'd2
    } term_state_e;

    // One char RAM write command.
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_cmd_t;

endpackage

// File: rtl/term_addr_calc.sv
// Screen (row, col) plus scroll base -> physical char RAM address.
// Ports:
//   row    : screen row 0..ROWS-1
//   base   : physical row holding screen row 0 (0..ROWS-1)
//   col    : column 0..COLS-1
//   addr_c : phys_row*COLS + col (combinational)
module term_addr_calc
    import term_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [ROW_W-1:0]  base,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr_c
);

    localparam int unsigned SUM_W = ROW_W + 1;

    logic [SUM_W-1:0] sum;
    logic [ROW_W-1:0] phys;

    // Both operands are below ROWS, so a single conditional subtract wraps;
    // x80 is built as x64 + x16.
    always_comb begin
        sum = {1'b0, row} + {1'b0, base};
        if (sum >= SUM_W'(ROWS)) begin
            phys = ROW_W'(sum - SUM_W'(ROWS));
        end else begin
            phys = sum[ROW_W-1:0];
        end
        addr_c = (ADDR_W'(phys) << 6) + (ADDR_W'(phys) << 4) + ADDR_W'(col);
    end

endmodule

// File: rtl/term_text_ctrl.sv
// Cursor/scroll controller for the 80x30 text buffer. Consumes a byte stream,
// interprets printable and control codes, writes the char RAM one cell per
// cycle and exports the circular-scroll row base used by the display.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_char  : input byte stream
//   in_ready          : high while idle; byte taken when in_valid && in_ready
//   wr_en/addr/data   : char RAM write strobe, address, ASCII data
//   row_base          : physical row holding screen row 0
//   cur_row/cur_col   : cursor screen position
module term_text_ctrl
    import term_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  row_base,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col
);

    localparam logic [7:0] TAB_MASK = ~8'(TAB_W - 1);

    term_state_e       state, state_d;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
    logic [ROW_W-1:0]  row_base_d, cur_row_d;
    logic [COL_W-1:0]  cur_col_d;
    logic              in_ready_d;
    wr_cmd_t           wr_q, wr_d;

    logic [COL_W-1:0]  calc_col_c;
    logic [ADDR_W-1:0] calc_addr_c;
    logic              accept;
    logic              do_nl;
    logic [7:0]        tab_sum;

    assign wr_en   = wr_q.en;
    assign wr_addr = wr_q.addr;
    assign wr_data = wr_q.data;
    assign accept  = in_valid && in_ready;

    // Column feeding the address calculator: line-clear counter, backspace
    // target, or the cursor itself.
    always_comb begin
        calc_col_c = cur_col;
        if (state == ST_CLR_LINE) begin
            calc_col_c = COL_W'(clr_cnt);
        end else if (in_char == CH_BS) begin
            calc_col_c = cur_col - COL_W'(1);
        end
    end

    term_addr_calc u_addr_calc (
        .row    (cur_row),
        .base   (row_base),
        .col    (calc_col_c),
        .addr_c (calc_addr_c)
    );

    // Next-state, cursor and write command.
    always_comb begin
        state_d    = state;
        clr_cnt_d  = clr_cnt;
        row_base_d = row_base;
        cur_row_d  = cur_row;
        cur_col_d  = cur_col;
        wr_d       = '{en: 1'b0, addr: wr_q.addr, data: wr_q.data};
        do_nl      = 1'b0;
        tab_sum    = ({1'b0, cur_col} & TAB_MASK) + 8'(TAB_W);

        case (state)
            ST_CLR_ALL: begin
                wr_d = '{en: 1'b1, addr: clr_cnt, data: CH_SP};
                if (clr_cnt == ADDR_W'(CELLS - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt + ADDR_W'(1);
                end
            end

            ST_CLR_LINE: begin
                wr_d = '{en: 1'b1, addr: calc_addr_c, data: CH_SP};
                if (clr_cnt == ADDR_W'(COLS - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    if (in_char >= CH_SP && in_char <= CH_PR_HI) begin
                        wr_d = '{en: 1'b1, addr: calc_addr_c, data: in_char};
                        if (cur_col == COL_W'(COLS - 1)) begin
                            cur_col_d = '0;
                            do_nl     = 1'b1;
                        end else begin
                            cur_col_d = cur_col + COL_W'(1);
                        end
                    end else begin
                        case (in_char)
                            CH_CR: cur_col_d = '0;
                            CH_LF: do_nl = 1'b1;
                            CH_BS: begin
                                if (cur_col != '0) begin
                                    cur_col_d = cur_col - COL_W'(1);
                                    wr_d = '{en: 1'b1, addr: calc_addr_c, data: CH_SP};
                                end
                            end
                            CH_TAB: begin
                                if (tab_sum >= 8'(COLS)) begin
                                    cur_col_d = '0;
                                    do_nl     = 1'b1;
                                end else begin
                                    cur_col_d = COL_W'(tab_sum);
                                end
                            end
                            CH_FF: begin
                                cur_row_d  = '0;
                                cur_col_d  = '0;
                                row_base_d = '0;
                                clr_cnt_d  = '0;
                                state_d    = ST_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: state_d = ST_CLR_ALL;
        endcase

        // Newline: step down, or scroll by advancing the base and blanking
        // the physical row that just became the bottom line.
        if (do_nl) begin
            if (cur_row < ROW_W'(ROWS - 1)) begin
                cur_row_d = cur_row + ROW_W'(1);
            end else begin
                row_base_d = (row_base == ROW_W'(ROWS - 1)) ? '0 : row_base + ROW_W'(1);
                clr_cnt_d  = '0;
                state_d    = ST_CLR_LINE;
            end
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLR_ALL;
            clr_cnt  <= '0;
            row_base <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            in_ready <= 1'b0;
            wr_q     <= '0;
        end else begin
            state    <= state_d;
            clr_cnt  <= clr_cnt_d;
            row_base <= row_base_d;
            cur_row  <= cur_row_d;
            cur_col  <= cur_col_d;
            in_ready <= in_ready_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_term_text_ctrl.sv
// Bench for term_text_ctrl: a cell/queue level model predicts every output on
// every cycle; directed sequences add hand-computed literal expectations.
module tb_term_text_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = 2400;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  row_base;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;

    always #5 clk = ~clk;

    term_text_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .row_base (row_base),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_row, m_col, m_base, m_waddr, m_wdata;
    bit m_ready, m_wen;
    int pend[$];   // cells still to be blanked, one per cycle

    function automatic int m_addr(input int r, input int c);
        return ((r + m_base) % ROWS) * COLS + c;
    endfunction

    function automatic void m_clear_all();
        pend.delete();
        for (int a = 0; a < CELLS; a++) pend.push_back(a);
        m_ready = 1'b0;
    endfunction

    function automatic void m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_base = (m_base + 1) % ROWS;
            for (int c = 0; c < COLS; c++) pend.push_back(m_addr(ROWS - 1, c));
            m_ready = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_row = 0; m_col = 0; m_base = 0;
        m_wen = 1'b0; m_waddr = 0; m_wdata = 0;
        m_clear_all();
    endfunction

    function automatic void m_step(input logic v, input logic [7:0] b);
        int nc;
        m_wen = 1'b0;
        if (pend.size() > 0) begin
            m_waddr = pend.pop_front();
            m_wen   = 1'b1;
            m_wdata = 32;
            if (pend.size() == 0) m_ready = 1'b1;
        end else if (m_ready && v) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                m_wen = 1'b1; m_waddr = m_addr(m_row, m_col); m_wdata = int'(b);
                m_col++;
                if (m_col == COLS) begin m_col = 0; m_newline(); end
            end else begin
                case (b)
                    8'h0D: m_col = 0;
                    8'h0A: m_newline();
                    8'h08: if (m_col > 0) begin
                        m_col--;
                        m_wen = 1'b1; m_waddr = m_addr(m_row, m_col); m_wdata = 32;
                    end
                    8'h09: begin
                        nc = (m_col / 8 + 1) * 8;
                        if (nc >= COLS) begin m_col = 0; m_newline(); end
                        else m_col = nc;
                    end
                    8'h0C: begin
                        m_row = 0; m_col = 0; m_base = 0;
                        m_clear_all();
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step(in_valid, in_char);
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc wr_en",    32'(wr_en),    32'(m_wen));
                check("cyc wr_addr",  32'(wr_addr),  m_waddr);
                check("cyc wr_data",  32'(wr_data),  m_wdata);
                check("cyc in_ready", 32'(in_ready), 32'(m_ready));
                check("cyc cur_row",  32'(cur_row),  m_row);
                check("cyc cur_col",  32'(cur_col),  m_col);
                check("cyc row_base", 32'(row_base), m_base);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    logic last_wen;
    int   last_addr, last_data;

    task automatic send(input logic [7:0] c);
        int budget = 0;
        while (in_ready !== 1'b1 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) check("send ready timeout", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_char  = c;
        @(negedge clk);
        in_valid  = 1'b0;
        last_wen  = wr_en;
        last_addr = int'(wr_addr);
        last_data = int'(wr_data);
    endtask

    task automatic wait_idle(output int cycles, output int writes,
                             output int first_a, output int last_a);
        cycles = 0; writes = 0; first_a = -1; last_a = -1;
        do begin
            @(negedge clk);
            cycles++;
            if (wr_en === 1'b1) begin
                writes++;
                if (first_a < 0) first_a = int'(wr_addr);
                last_a = int'(wr_addr);
            end
        end while (in_ready !== 1'b1 && cycles < 3000);
        if (in_ready !== 1'b1) check("wait_idle timeout", 32'(in_ready), 1);
    endtask

    int cyc, nw, fa, la, wsum;

    initial begin
        in_valid = 1'b0;
        in_char  = 8'h00;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst wr_en",    32'(wr_en),    0);
        check("rst wr_addr",  32'(wr_addr),  0);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst row_base", 32'(row_base), 0);
        check("rst cursor",   {cur_row, cur_col}, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Power-up clear
        wait_idle(cyc, nw, fa, la);
        check("init clr cycles", cyc, 2400);
        check("init clr writes", nw, 2400);
        check("init clr first",  fa, 0);
        check("init clr last",   la, 2399);
        check("init ready",      32'(in_ready), 1);

        // "AB" back to back
        send("A");
        check("A wen",  32'(last_wen), 1);
        check("A addr", last_addr, 0);
        check("A data", last_data, 8'h41);
        send("B");
        check("B addr", last_addr, 1);
        check("B data", last_data, 8'h42);
        check("AB col", 32'(cur_col), 2);
        check("AB ready", 32'(in_ready), 1);

        // Form feed mid-text
        send(8'h0C);
        check("FF wen",    32'(last_wen), 0);
        check("FF cursor", {cur_row, cur_col}, 0);
        check("FF ready",  32'(in_ready), 0);
        wait_idle(cyc, nw, fa, la);
        check("FF clr writes", nw, 2400);
        check("FF clr first",  fa, 0);

        // 80 x 'x' wraps to the next line
        for (int i = 0; i < 80; i++) send("x");
        check("80x last addr", last_addr, 79);
        check("80x last data", last_data, 8'h78);
        check("80x row", 32'(cur_row), 1);
        check("80x col", 32'(cur_col), 0);

        // CR, TAB, TAB
        wsum = 0;
        send(8'h0D); wsum += int'(last_wen);
        send(8'h09); wsum += int'(last_wen);
        send(8'h09); wsum += int'(last_wen);
        check("tab col", 32'(cur_col), 16);
        check("tab writes", wsum, 0);

        // Down to row 29, col 5, then scroll
        send(8'h0D);
        repeat (28) send(8'h0A);
        check("row29", 32'(cur_row), 29);
        send("a"); send("b"); send("c"); send("d"); send("e");
        send(8'h0A);
        check("scroll base", 32'(row_base), 1);
        check("scroll row",  32'(cur_row), 29);
        check("scroll col",  32'(cur_col), 5);
        check("scroll ready", 32'(in_ready), 0);
        wait_idle(cyc, nw, fa, la);
        check("line clr cycles", cyc, 80);
        check("line clr writes", nw, 80);
        check("line clr first",  fa, 0);
        check("line clr last",   la, 79);
        send("Q");
        check("Q addr", last_addr, 5);
        check("Q data", last_data, 8'h51);

        // Scroll until base 29
        for (int i = 0; i < 28; i++) begin
            send(8'h0A);
            wait_idle(cyc, nw, fa, la);
        end
        check("base29", 32'(row_base), 29);

        // Bottom-right printable: write, then scroll
        send(8'h0D);
        repeat (9) send(8'h09);
        repeat (7) send(".");
        check("col79", 32'(cur_col), 79);
        send("Z");
        check("Z addr", last_addr, 2319);
        check("Z data", last_data, 8'h5A);
        check("Z base", 32'(row_base), 0);
        check("Z col",  32'(cur_col), 0);
        wait_idle(cyc, nw, fa, la);
        check("Z clr writes", nw, 80);
        check("Z clr first",  fa, 2320);
        check("Z clr last",   la, 2399);

        // Backspace
        send(8'h08);
        check("BS0 wen", 32'(last_wen), 0);
        check("BS0 col", 32'(cur_col), 0);
        send("a"); send("b"); send("c");
        send(8'h08);
        check("BS3 wen",  32'(last_wen), 1);
        check("BS3 addr", last_addr, 2322);
        check("BS3 data", last_data, 8'h20);
        check("BS3 col",  32'(cur_col), 2);

        // Reset during a line clear
        send(8'h0A);
        repeat (10) @(negedge clk);
        check("mid clr wen", 32'(wr_en), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("rst2 wen",   32'(wr_en), 0);
        check("rst2 ready", 32'(in_ready), 0);
        check("rst2 base",  32'(row_base), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        wait_idle(cyc, nw, fa, la);
        check("rst2 clr writes", nw, 2400);
        check("rst2 clr first",  fa, 0);
        check("rst2 cursor", {cur_row, cur_col}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
